// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, flush length and sign-extend/saturate helpers for the GEMM array
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;
  localparam int MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction
  function automatic wide_t sext(input wide_t v, input int w);
    return (v << (MAX_W - w)) >>> (MAX_W - w);
  endfunction
  function automatic wide_t lim_hi(input int w);
    return $signed((MAX_W'(1) << (w - 1)) - MAX_W'(1));
  endfunction
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    wide_t s;
    s = a + b;
    return (s > lim_hi(w)) ? lim_hi(w) : (s < ~lim_hi(w)) ? ~lim_hi(w) : s;
  endfunction
  function automatic logic sat_hit(input wide_t a, input wide_t b, input int w);
    wide_t s;
    s = a + b;
    return (s > lim_hi(w)) || (s < ~lim_hi(w));
  endfunction
endpackage

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: one valid-gated MAC cell with registered east/south pass-through.
// SYSTOLIC_ACC_SATURATE_EN selects saturating accumulation and a sticky sat_o flag.
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic                  a_vld_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  b_vld_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic                  a_vld_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  b_vld_o,
`ifdef SYSTOLIC_ACC_SATURATE_EN
  output logic                  sat_o,
`endif
  output logic [ACC_WIDTH-1:0]  acc_o
);
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  wide_t acc_x, prod_x;
  assign prod   = $signed(a_i) * $signed(b_i);
  assign acc_x  = sext(MAX_W'(acc_q), ACC_WIDTH);
  assign prod_x = sext(MAX_W'(prod), 2 * DATA_WIDTH);
  assign acc_o  = acc_q;
`ifdef SYSTOLIC_ACC_SATURATE_EN
  logic sat_q;
  assign acc_d = ACC_WIDTH'(sat_add(acc_x, prod_x, ACC_WIDTH));
  assign sat_o = sat_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) sat_q <= 1'b0;
    else if (a_vld_i && b_vld_i) sat_q <= sat_q | sat_hit(acc_x, prod_x, ACC_WIDTH);
  end
`else
  assign acc_d = ACC_WIDTH'(acc_x + prod_x);
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_o     <= '0;
      a_vld_o <= 1'b0;
      b_o     <= '0;
      b_vld_o <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_o     <= a_i;
      a_vld_o <= a_vld_i;
      b_o     <= b_i;
      b_vld_o <= b_vld_i;
      if (clr_i) acc_q <= '0;
      else if (a_vld_i && b_vld_i) acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/systolic_gemm_array.sv
// systolic_gemm_array: ROWS x COLS output-stationary GEMM tile with input skew, run-time K and row drain.
// SYSTOLIC_ACC_SATURATE_EN adds saturating accumulators and the sat_o port.
module systolic_gemm_array
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 12,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [K_WIDTH-1:0]        k_len_i,
  output logic                      busy_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0] a_i,
  input  logic [COLS*DATA_WIDTH-1:0] b_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [COLS*ACC_WIDTH-1:0] out_data_o,
  output logic [RW-1:0]             out_row_o,
  output logic                      out_last_o,
`ifdef SYSTOLIC_ACC_SATURATE_EN
  output logic                      sat_o,
`endif
  output logic                      done_o
);
  localparam int FL   = flush_len(ROWS, COLS);
  localparam int FL_W = $clog2(FL + 1);
  state_e state_q;
  logic [K_WIDTH-1:0] k_q, beat_q;
  logic [FL_W-1:0] fl_q;
  logic [RW-1:0] row_q;
  logic out_valid_q, done_q, hs, clr;
  logic [DATA_WIDTH-1:0] a_sk [ROWS];
  logic [DATA_WIDTH-1:0] b_sk [COLS];
  logic av_sk [ROWS];
  logic bv_sk [COLS];
  logic [DATA_WIDTH-1:0] ah [ROWS][COLS];
  logic [DATA_WIDTH-1:0] bh [ROWS][COLS];
  logic avh [ROWS][COLS];
  logic bvh [ROWS][COLS];
  logic [ACC_WIDTH-1:0] acc [ROWS][COLS];
  logic [COLS*ACC_WIDTH-1:0] row_w [ROWS];
  logic [ROWS-1:0] unused_e;
  logic [COLS-1:0] unused_s;
`ifdef SYSTOLIC_ACC_SATURATE_EN
  logic [ROWS*COLS-1:0] sat_w;
  assign sat_o = |sat_w;
`endif
  assign hs          = in_valid_i && in_ready_o;
  assign clr         = (state_q == IDLE) && start_i;
  assign busy_o      = state_q != IDLE;
  assign in_ready_o  = state_q == LOAD;
  assign out_valid_o = out_valid_q;
  assign out_row_o   = row_q;
  assign out_last_o  = out_valid_q && (row_q == RW'(ROWS - 1));
  assign out_data_o  = out_valid_q ? row_w[row_q] : '0;
  assign done_o      = done_q;
  // Row r of A is held back r cycles so operands meet on the PE anti-diagonals.
  for (genvar r = 0; r < ROWS; r++) begin : g_ask
    if (r == 0) begin : g_z
      assign a_sk[r]  = a_i[0 +: DATA_WIDTH];
      assign av_sk[r] = hs;
    end else begin : g_d
      logic [DATA_WIDTH-1:0] d_q [r];
      logic [r-1:0] v_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v_q <= '0;
          for (int i = 0; i < r; i++) d_q[i] <= '0;
        end else begin
          d_q[0] <= a_i[r*DATA_WIDTH +: DATA_WIDTH];
          v_q[0] <= hs;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign a_sk[r]  = d_q[r-1];
      assign av_sk[r] = v_q[r-1];
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_bsk
    if (c == 0) begin : g_z
      assign b_sk[c]  = b_i[0 +: DATA_WIDTH];
      assign bv_sk[c] = hs;
    end else begin : g_d
      logic [DATA_WIDTH-1:0] d_q [c];
      logic [c-1:0] v_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v_q <= '0;
          for (int i = 0; i < c; i++) d_q[i] <= '0;
        end else begin
          d_q[0] <= b_i[c*DATA_WIDTH +: DATA_WIDTH];
          v_q[0] <= hs;
          for (int i = 1; i < c; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign b_sk[c]  = d_q[c-1];
      assign bv_sk[c] = v_q[c-1];
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in;
      logic av_in, bv_in;
      if (c == 0) begin : g_w
        assign a_in  = a_sk[r];
        assign av_in = av_sk[r];
      end else begin : g_e
        assign a_in  = ah[r][c-1];
        assign av_in = avh[r][c-1];
      end
      if (r == 0) begin : g_n
        assign b_in  = b_sk[c];
        assign bv_in = bv_sk[c];
      end else begin : g_s
        assign b_in  = bh[r-1][c];
        assign bv_in = bvh[r-1][c];
      end
      if (c == COLS - 1) begin : g_le
        assign unused_e[r] = ^{ah[r][c], avh[r][c]};
      end
      if (r == ROWS - 1) begin : g_ls
        assign unused_s[c] = ^{bh[r][c], bvh[r][c]};
      end
      systolic_mac_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr),
        .a_i     (a_in),
        .a_vld_i (av_in),
        .b_i     (b_in),
        .b_vld_i (bv_in),
        .a_o     (ah[r][c]),
        .a_vld_o (avh[r][c]),
        .b_o     (bh[r][c]),
        .b_vld_o (bvh[r][c]),
`ifdef SYSTOLIC_ACC_SATURATE_EN
        .sat_o   (sat_w[r*COLS+c]),
`endif
        .acc_o   (acc[r][c])
      );
      assign row_w[r][c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      fl_q        <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          k_q         <= k_len_i;
          beat_q      <= '0;
          row_q       <= '0;
          out_valid_q <= k_len_i == '0;
          state_q     <= (k_len_i == '0) ? DRAIN : LOAD;
        end
        LOAD: if (in_valid_i) begin
          beat_q <= beat_q + K_WIDTH'(1);
          if (beat_q == k_q - K_WIDTH'(1)) begin
            fl_q    <= '0;
            state_q <= FLUSH;
          end
        end
        // Last operand reaches the far corner PE exactly as the flush window closes.
        FLUSH: if (fl_q == FL_W'(FL - 1)) begin
          out_valid_q <= 1'b1;
          row_q       <= '0;
          state_q     <= DRAIN;
        end else fl_q <= fl_q + FL_W'(1);
        DRAIN: if (out_ready_i) begin
          if (row_q == RW'(ROWS - 1)) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end else row_q <= row_q + RW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_gemm_array.sv
// tb_systolic_gemm_array: directed tiles on a 4x4, 16-bit operand, 32-bit accumulator array
module tb_systolic_gemm_array;
  localparam int R = 4, C = 4, DW = 16, AW = 32, KW = 12;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, out_last, done, busy;
  logic [KW-1:0] k_len;
  logic [R*DW-1:0] a;
  logic [C*DW-1:0] b;
  logic [C*AW-1:0] out_data;
  logic [1:0] out_row;
`ifdef SYSTOLIC_ACC_SATURATE_EN
  logic sat;
`endif
  int checks = 0, errors = 0;
  logic [R*DW-1:0] av [4];
  logic [C*DW-1:0] bv [4];
  logic [C*AW-1:0] ex [R];

  always #5 clk = ~clk;

  systolic_gemm_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .k_len_i     (k_len),
    .busy_o      (busy),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_row_o   (out_row),
    .out_last_o  (out_last),
`ifdef SYSTOLIC_ACC_SATURATE_EN
    .sat_o       (sat),
`endif
    .done_o      (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] v4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  function automatic logic [127:0] row4(input int e0, input int e1, input int e2, input int e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_ovld"}, out_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
  endtask

  task automatic run(input string tag, input int k, input bit gaps, input int stall);
    int i, n;
    bit tg, hs;
    i = 0; n = 0; tg = 1'b1;
    start = 1'b1; k_len = KW'(k);
    step();
    start = 1'b0;
    while (i < k && n < 64) begin
      in_valid = gaps ? tg : 1'b1;
      a = av[i]; b = bv[i];
      hs = in_valid && in_ready;
      step();
      if (hs) i++;
      tg = !tg; n++;
    end
    in_valid = 1'b0;
    if (k > 0) check({tag, "_ready_drop"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 32) begin
      step();
      n++;
    end
    check({tag, "_drain_start"}, out_valid, 1);
    for (int r = 0; r < R; r++) begin
      if (r == 0 && stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          step();
          check({tag, "_stall_data"}, out_data, ex[0]);
          check({tag, "_stall_row"}, out_row, 0);
          check({tag, "_stall_vld"}, out_valid, 1);
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s_row%0d_data", tag, r), out_data, ex[r]);
      check($sformatf("%s_row%0d_idx", tag, r), out_row, 128'(r));
      check($sformatf("%s_row%0d_last", tag, r), out_last, 128'(r == R - 1));
      step();
    end
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    step();
    check({tag, "_done_clear"}, done, 0);
  endtask

  task automatic load_2x2();
    av[0] = v4(1, 3, 0, 0); bv[0] = v4(5, 6, 0, 0);
    av[1] = v4(2, 4, 0, 0); bv[1] = v4(7, 8, 0, 0);
    ex[0] = row4(19, 22, 0, 0); ex[1] = row4(43, 50, 0, 0);
    ex[2] = '0; ex[3] = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    step(); step();
    idle_outputs("reset");
    rst = 1'b0;
    step();
    load_2x2();
    run("t2x2", 2, 1'b0, 0);
    av[0] = v4(1, 4, -1, 2);  bv[0] = v4(1, 0, 2, -1);
    av[1] = v4(2, 5, 0, -2);  bv[1] = v4(0, 1, 1, 3);
    av[2] = v4(3, 6, 1, 2);   bv[2] = v4(2, -1, 0, 1);
    ex[0] = row4(7, -1, 4, 8);
    ex[1] = row4(16, -1, 13, 17);
    ex[2] = row4(1, -1, -2, 2);
    ex[3] = row4(6, -4, 2, -6);
    run("t4x4", 3, 1'b0, 0);
    run("t4x4gap", 3, 1'b1, 0);
    av[0] = v4(-3, 2, 0, 0); bv[0] = v4(4, -5, 7, 0);
    ex[0] = row4(-12, 15, -21, 0); ex[1] = row4(8, -10, 14, 0);
    ex[2] = '0; ex[3] = '0;
    run("tstall", 1, 1'b0, 5);
    ex[0] = '0; ex[1] = '0;
    run("tk0", 0, 1'b0, 0);
    start = 1'b1; k_len = KW'(3);
    step();
    start = 1'b0; in_valid = 1'b1; a = v4(100, 200, 300, 400); b = v4(9, 9, 9, 9);
    step();
    in_valid = 1'b0;
    step();
    check("abort_busy", busy, 1);
    rst = 1'b1;
    step();
    idle_outputs("abort");
    rst = 1'b0;
    step();
    load_2x2();
    run("tafter", 2, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      av[i] = v4(32767, 32767, 32767, 32767);
      bv[i] = v4(32767, 32767, 32767, 32767);
    end
`ifdef SYSTOLIC_ACC_SATURATE_EN
    for (int r = 0; r < R; r++) ex[r] = {4{32'h7FFFFFFF}};
`else
    for (int r = 0; r < R; r++) ex[r] = {4{32'hBFFD0003}};
`endif
    run("tovf", 3, 1'b0, 0);
`ifdef SYSTOLIC_ACC_SATURATE_EN
    check("tovf_sat", sat, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
